scan_reg_bank: RTL
==================

SCAN_REG_BANK -- requirements
Module: scan_reg_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the number of stored bits, legal range 2..64.
REQ-002 SHALL have parameter RST_VAL, default all-zeros, meaning the WIDTH-bit internal state loaded by RST.
REQ-003 SHALL have parameter SET_VAL, default all-ones, meaning the WIDTH-bit internal state loaded by SETN low.
REQ-004 SHALL have port CLK, input, width 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port RST, input, width 1, the reset, synchronous and active-high.
REQ-006 SHALL have port SETN, input, width 1, synchronous set, active-low.
REQ-007 SHALL have port SE, input, width 1, scan enable.
REQ-008 SHALL have port SI, input, width 1, scan serial in, feeding bit 0.
REQ-009 SHALL have port EN, input, width 1, functional load enable.
REQ-010 SHALL have port D, input, width WIDTH, functional parallel data.
REQ-011 SHALL have port Q, output, width WIDTH, the bitwise complement of internal state IQ.
REQ-012 SHALL have port SO, output, width 1, scan out, equal to IQ[WIDTH-1].
REQ-013 SHALL have port SHIFT_DONE, output, width 1, a one-cycle pulse marking a full-chain shift.

Function
REQ-014 SHALL apply the per-edge priority RST > SETN low > SE high > EN high > hold.
REQ-015 SHALL, on a shift edge, set IQ <= {IQ[WIDTH-2:0], SI}, so SI enters bit 0 and bit WIDTH-1 leaves via SO.
REQ-016 SHALL, on a load edge (SE low, EN high), set IQ <= D.
REQ-017 SHALL hold IQ when SE and EN are both low.
REQ-018 SHALL drive Q and SO combinationally from IQ with no added latency; a new value is visible after the capturing edge.
REQ-019 SHALL keep a shift counter CNT of width clog2(WIDTH+1); CNT increments on each shift edge.
REQ-020 SHALL, on the edge where CNT reaches WIDTH, register SHIFT_DONE high for exactly one cycle and wrap CNT to 0 on the same edge.
REQ-021 SHALL clear CNT to 0 on any edge where SE is low, SETN is low, or RST is high, so only consecutive shifts count.
REQ-022 SHALL, when SE and EN are both high, shift only; D is ignored.
REQ-023 SHALL, when SETN is low and SE is high on the same edge, load SET_VAL, leave CNT at 0 and keep SHIFT_DONE low.

Reset
REQ-024 SHALL, on an RST edge, set IQ=RST_VAL (Q=~RST_VAL, SO=RST_VAL[WIDTH-1]), CNT=0 and SHIFT_DONE=0; RST mid-shift aborts the count.
REQ-025 SHALL give RST priority over a simultaneous SETN low.

Configuration
REQ-026 SHALL implement the macro SCAN_REG_BANK_PARITY_EN.
REQ-027 SHALL, with SCAN_REG_BANK_PARITY_EN defined, add output PAR (width 1) equal to the XOR of all IQ bits, registered so that it is valid the cycle after each IQ update, with reset value ^RST_VAL.
REQ-028 SHALL, without SCAN_REG_BANK_PARITY_EN, have no PAR port and no parity logic.

Structure
REQ-029 SHALL place in the shared package scan_reg_pkg the function computing the CNT width (clog2(WIDTH+1)) and a mode enum {MODE_HOLD, MODE_LOAD, MODE_SHIFT, MODE_SET, MODE_RST}.
REQ-030 SHALL implement the per-bit next-state logic in one sub-module, scan_reg_bit (mux D/SI, set, reset), instantiated WIDTH times; CNT and SHIFT_DONE stay in the top level.

Verification
REQ-031 SHALL cover this directed scenario, with WIDTH=8: RST=1 for one edge -> Q=8'hFF, SO=0, SHIFT_DONE=0.
REQ-032 SHALL cover this directed scenario: EN=1, SE=0, D=8'hA5 -> next cycle Q=8'h5A; with EN=0 for 3 cycles, Q holds at 8'h5A.
REQ-033 SHALL cover this directed scenario: after loading 8'hA5, SE=1 for 8 edges with SI=0 -> SO sequence 1,0,1,0,0,1,0,1; SHIFT_DONE pulses after the 8th edge only; Q=8'hFF.
REQ-034 SHALL cover this directed scenario: SE=1 for 5 edges, SE=0 for 1 edge, SE=1 for 8 edges -> SHIFT_DONE only after the final 8th consecutive shift.
REQ-035 SHALL cover this directed scenario: SETN=0 with SE=1 and RST=0 -> Q=8'h00 and CNT=0; SETN=0 with RST=1 -> Q=8'hFF.
REQ-036 SHALL cover this directed scenario with SCAN_REG_BANK_PARITY_EN defined: load 8'h07 -> PAR=1 one cycle later; load 8'h03 -> PAR=0.

Source files
------------

// File: rtl/scan_reg_pkg.sv
// Shared types and helpers for the scan register bank: operating modes,
// shift-counter width and a parity helper.
package scan_reg_pkg;

   typedef enum logic [2:0] {
      MODE_HOLD  = 3'd0,
      MODE_LOAD  = 3'd1,
      MODE_SHIFT = 3'd2,
      MODE_SET   = 3'd3,
      MODE_RST   = 3'd4
   } mode_e;

   // Counter must be able to represent WIDTH itself.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

   function automatic logic parity64(input logic [63:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/scan_reg_bit.sv
// One stored bit of the scan register bank: selects reset / set / scan / load /
// hold according to the mode decoded once in the top level.
module scan_reg_bit
   import scan_reg_pkg::*;
#(
   parameter logic RST_BIT = 1'b0,
   parameter logic SET_BIT = 1'b1
) (
   input  logic  i_clk,
   input  logic  i_rst,
   input  mode_e i_mode,
   input  logic  i_d,
   input  logic  i_si,
   output logic  o_q
);

   logic r_q;
   logic w_nxt;

   // Next-state selection for this bit.
   always_comb begin
      w_nxt = r_q;
      case (i_mode)
         MODE_RST:   w_nxt = RST_BIT;
         MODE_SET:   w_nxt = SET_BIT;
         MODE_SHIFT: w_nxt = i_si;
         MODE_LOAD:  w_nxt = i_d;
         MODE_HOLD:  w_nxt = r_q;
         default:    w_nxt = r_q;
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_q <= RST_BIT;
      end else begin
         r_q <= w_nxt;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/scan_reg_bank.sv
// Scan register bank: WIDTH scan flops with set/reset/load/shift, a shift
// counter and full-chain SHIFT_DONE pulse. Optional PAR output: SCAN_REG_BANK_PARITY_EN.
module scan_reg_bank
   import scan_reg_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
   parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{1'b1}}
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             SETN,
   input  logic             SE,
   input  logic             SI,
   input  logic             EN,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             SO,
   output logic             SHIFT_DONE
`ifdef SCAN_REG_BANK_PARITY_EN
   ,
   output logic             PAR
`endif
);

   localparam int             CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

   mode_e            w_mode;
   logic [WIDTH-1:0] w_iq;
   logic [WIDTH-1:0] w_si;
   logic [CW-1:0]    r_cnt;
   logic             r_done;

   // Edge priority: reset, set, shift, load, hold.
   always_comb begin
      w_mode = MODE_HOLD;
      if (RST) begin
         w_mode = MODE_RST;
      end else if (!SETN) begin
         w_mode = MODE_SET;
      end else if (SE) begin
         w_mode = MODE_SHIFT;
      end else if (EN) begin
         w_mode = MODE_LOAD;
      end else begin
         w_mode = MODE_HOLD;
      end
   end

   assign w_si = {w_iq[WIDTH-2:0], SI};

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      scan_reg_bit #(
         .RST_BIT (RST_VAL[i]),
         .SET_BIT (SET_VAL[i])
      ) u_bit (
         .i_clk  (CLK),
         .i_rst  (RST),
         .i_mode (w_mode),
         .i_d    (D[i]),
         .i_si   (w_si[i]),
         .o_q    (w_iq[i])
      );
   end

   // Counts consecutive shift edges only; any non-shift edge restarts the count.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_cnt  <= {CW{1'b0}};
         r_done <= 1'b0;
      end else if (w_mode != MODE_SHIFT) begin
         r_cnt  <= {CW{1'b0}};
         r_done <= 1'b0;
      end else if (r_cnt == CNT_LAST) begin
         r_cnt  <= {CW{1'b0}};
         r_done <= 1'b1;
      end else begin
         r_cnt  <= r_cnt + CW'(1);
         r_done <= 1'b0;
      end
   end

   assign Q          = ~w_iq;
   assign SO         = w_iq[WIDTH-1];
   assign SHIFT_DONE = r_done;

`ifdef SCAN_REG_BANK_PARITY_EN
   logic r_par;

   // Parity lags the stored word by one edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_par <= ^RST_VAL;
      end else begin
         r_par <= parity64(64'(w_iq));
      end
   end

   assign PAR = r_par;
`endif

endmodule
